corral_ctrl: RTL and testbench
==============================

CORRAL_CTRL -- requirements
Module: corral_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, sets the WAIT-state cycle budget before a timeout (used only with CORRAL_TIMEOUT_EN).
REQ-002 clock  in  1  rising-edge clock for all sequential logic.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 move_valid  in  1  requester offers a move.
REQ-005 move  in  3  move code, qualified by move_valid.
REQ-006 move_ready  out  1  controller can accept a move this cycle.
REQ-007 new_game  in  1  restart request, honoured only in OVER.
REQ-008 game_enter  out  1  one-cycle command strobe to the game engine.
REQ-009 game_move  out  3  move code presented with game_enter.
REQ-010 game_ready  in  1  game engine result-valid.
REQ-011 game_cowboypos, game_horsepos  in  4 each  engine positions, valid with game_ready.
REQ-012 game_gameover, game_lostwon  in  1 each  engine status, valid with game_ready.
REQ-013 data  out  4  multiplexed display word.
REQ-014 data_sel  out  2  data content: 0 cowboy, 1 horse, 2 status.
REQ-015 data_valid  out  1  data/data_sel valid.
REQ-016 gameover, lostwon  out  1 each  registered game status.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.
REQ-018 timeout_err  out  1  sticky engine-timeout flag.

Function
REQ-019 Moves SHALL be buffered in a 2-entry FIFO; move_ready = !full && state!=OVER; push on move_valid && move_ready; no same-cycle push when full, even if popping; no bypass when empty.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, SHOW_C, SHOW_H, SHOW_S, OVER.
REQ-021 In IDLE with the FIFO non-empty, the controller SHALL pop the head into a move register and go to ISSUE; game_enter therefore rises exactly 2 edges after the accepting edge.
REQ-022 In ISSUE, game_enter=1 and game_move=move register for exactly one cycle, then WAIT; game_ready in ISSUE is ignored.
REQ-023 In WAIT, game_ready=1 SHALL capture both positions and both status bits on that edge and go to SHOW_C; gameover and lostwon outputs update on the same edge.
REQ-024 SHOW_C: data=cowboypos, sel=0; SHOW_H: data=horsepos, sel=1; SHOW_S: data={2'b00,gameover,lostwon}, sel=2; data_valid=1 in all three for one cycle each, otherwise data=0, sel=0, data_valid=0.
REQ-025 After SHOW_S, go to OVER if captured gameover=1, else IDLE.
REQ-026 In OVER the FIFO SHALL be flushed, and new_game=1 SHALL clear gameover, lostwon and timeout_err and return to IDLE; new_game elsewhere is ignored.
REQ-027 Moves arriving during any non-OVER state SHALL still be queued, subject to REQ-019.

Reset
REQ-028 On reset_n low: state IDLE, FIFO empty, and all outputs 0 (including gameover, lostwon, timeout_err, game_enter); move_ready=1 from the first cycle after release.
REQ-029 A reset mid-transaction SHALL abandon it without any further game_enter.

Configuration
REQ-030 With CORRAL_TIMEOUT_EN defined: a counter runs in WAIT; if TIMEOUT_CYCLES cycles elapse without game_ready, set timeout_err=1, gameover=1, lostwon=0 and go to OVER, skipping the SHOW states.
REQ-031 Without CORRAL_TIMEOUT_EN: WAIT waits indefinitely, there is no counter, and timeout_err is a constant 0.

Structure
REQ-032 Package corral_pkg SHALL hold the state enum, MOVE_W=3, POS_W=4 and the data_sel encodings.
REQ-033 The FIFO SHALL be the sub-module corral_move_fifo (depth 2, width MOVE_W, with a flush input).

Verification
REQ-034 Single move: push move=3'b101, engine replies ready after 4 cycles with cowboy=4'h2, horse=4'h9, gameover=0 -> game_enter 2 edges after accept with game_move=101; data sequence 2/9/0 with sel 0/1/2; return to IDLE.
REQ-035 Backpressure: three back-to-back moves while the engine stalls -> two accepted, move_ready=0 on the third; the moves are issued in order.
REQ-036 Game over: reply with gameover=1, lostwon=1 -> status word 4'b0011; state OVER; move_ready=0 until new_game; then flags cleared.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=8): no game_ready -> timeout_err=1 and gameover=1 after 8 WAIT cycles, with no data_valid.
REQ-038 Reset mid-WAIT with one move queued -> all outputs 0, no further game_enter, FIFO empty.

Source files
------------

// File: rtl/corral_pkg.sv
// Shared types and constants for the corral game controller: FSM states,
// field widths and the data_sel encodings of the display word.
package corral_pkg;

    localparam int MOVE_W = 3;
    localparam int POS_W  = 4;

    localparam logic [1:0] SEL_COWBOY = 2'd0;
    localparam logic [1:0] SEL_HORSE  = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SHOW_C = 3'd3,
        ST_SHOW_H = 3'd4,
        ST_SHOW_S = 3'd5,
        ST_OVER   = 3'd6
    } state_e;

    function automatic logic [POS_W-1:0] status_word(input logic go, input logic lw);
        return {2'b00, go, lw};
    endfunction

endpackage

// File: rtl/corral_if.sv
// Bundle of the requester, game-engine and display signals of corral_ctrl.
// The controller takes the slave view; the environment takes the master view.
interface corral_if;
    import corral_pkg::*;

    logic              move_valid;
    logic [MOVE_W-1:0] move;
    logic              move_ready;
    logic              new_game;
    logic              game_enter;
    logic [MOVE_W-1:0] game_move;
    logic              game_ready;
    logic [POS_W-1:0]  game_cowboypos;
    logic [POS_W-1:0]  game_horsepos;
    logic              game_gameover;
    logic              game_lostwon;
    logic [POS_W-1:0]  data;
    logic [1:0]        data_sel;
    logic              data_valid;
    logic              gameover;
    logic              lostwon;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  move_valid, move, new_game, game_ready, game_cowboypos,
               game_horsepos, game_gameover, game_lostwon,
        output move_ready, game_enter, game_move, data, data_sel, data_valid,
               gameover, lostwon, busy, timeout_err
    );

    modport master (
        output move_valid, move, new_game, game_ready, game_cowboypos,
               game_horsepos, game_gameover, game_lostwon,
        input  move_ready, game_enter, game_move, data, data_sel, data_valid,
               gameover, lostwon, busy, timeout_err
    );

endinterface

// File: rtl/corral_move_fifo.sv
// Two-entry move queue with synchronous flush. Callers must not push when
// full or pop when empty; such requests are dropped.
module corral_move_fifo
    import corral_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [MOVE_W-1:0] data_i,
    input  logic              pop_i,
    output logic [MOVE_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [MOVE_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              push_s;
    logic              pop_s;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;

    // Storage, pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= {MOVE_W{1'b0}};
            mem_q[1] <= {MOVE_W{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/corral_ctrl.sv
// Corral game controller: queues requester moves, issues them one at a time
// to the game engine and shows the result. CORRAL_TIMEOUT_EN adds a WAIT timeout.
module corral_ctrl
    import corral_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic     clock,
    input  logic     reset_n,
    corral_if.slave  bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("corral_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q;
    logic [MOVE_W-1:0] move_q;
    logic              game_enter_q;
    logic [MOVE_W-1:0] game_move_q;
    logic [POS_W-1:0]  horse_q;
    logic [POS_W-1:0]  data_q;
    logic [1:0]        data_sel_q;
    logic              data_valid_q;
    logic              gameover_q;
    logic              lostwon_q;

    logic              move_ready_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_flush_s;
    logic [MOVE_W-1:0] fifo_head_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;

    // Ready is held low while in reset so nothing is offered before release.
    assign move_ready_s = reset_n && !fifo_full_s && (state_q != ST_OVER);
    assign fifo_push_s  = bus.move_valid && move_ready_s;
    assign fifo_pop_s   = (state_q == ST_IDLE) && !fifo_empty_s;
    assign fifo_flush_s = (state_q == ST_OVER);

    corral_move_fifo u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush_i (fifo_flush_s),
        .push_i  (fifo_push_s),
        .data_i  (bus.move),
        .pop_i   (fifo_pop_s),
        .data_o  (fifo_head_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

`ifdef CORRAL_TIMEOUT_EN
    localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_err_q;

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Main FSM; every output is produced from a register updated here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            move_q        <= {MOVE_W{1'b0}};
            game_enter_q  <= 1'b0;
            game_move_q   <= {MOVE_W{1'b0}};
            horse_q       <= {POS_W{1'b0}};
            data_q        <= {POS_W{1'b0}};
            data_sel_q    <= SEL_COWBOY;
            data_valid_q  <= 1'b0;
            gameover_q    <= 1'b0;
            lostwon_q     <= 1'b0;
`ifdef CORRAL_TIMEOUT_EN
            tmo_cnt_q     <= {TMO_W{1'b0}};
            timeout_err_q <= 1'b0;
`endif
        end else begin
            game_enter_q <= 1'b0;
            game_move_q  <= {MOVE_W{1'b0}};
            data_q       <= {POS_W{1'b0}};
            data_sel_q   <= SEL_COWBOY;
            data_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        move_q  <= fifo_head_s;
                        state_q <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    game_enter_q <= 1'b1;
                    game_move_q  <= move_q;
`ifdef CORRAL_TIMEOUT_EN
                    tmo_cnt_q    <= {TMO_W{1'b0}};
`endif
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.game_ready) begin
                        horse_q      <= bus.game_horsepos;
                        gameover_q   <= bus.game_gameover;
                        lostwon_q    <= bus.game_lostwon;
                        data_q       <= bus.game_cowboypos;
                        data_sel_q   <= SEL_COWBOY;
                        data_valid_q <= 1'b1;
                        state_q      <= ST_SHOW_C;
`ifdef CORRAL_TIMEOUT_EN
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        timeout_err_q <= 1'b1;
                        gameover_q    <= 1'b1;
                        lostwon_q     <= 1'b0;
                        state_q       <= ST_OVER;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        state_q   <= ST_WAIT;
                    end
`else
                    end else begin
                        state_q <= ST_WAIT;
                    end
`endif
                end
                ST_SHOW_C: begin
                    data_q       <= horse_q;
                    data_sel_q   <= SEL_HORSE;
                    data_valid_q <= 1'b1;
                    state_q      <= ST_SHOW_H;
                end
                ST_SHOW_H: begin
                    data_q       <= status_word(gameover_q, lostwon_q);
                    data_sel_q   <= SEL_STATUS;
                    data_valid_q <= 1'b1;
                    state_q      <= ST_SHOW_S;
                end
                ST_SHOW_S: begin
                    state_q <= gameover_q ? ST_OVER : ST_IDLE;
                end
                ST_OVER: begin
                    if (bus.new_game) begin
                        gameover_q    <= 1'b0;
                        lostwon_q     <= 1'b0;
`ifdef CORRAL_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                        state_q       <= ST_IDLE;
                    end else begin
                        state_q <= ST_OVER;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.move_ready = move_ready_s;
    assign bus.game_enter = game_enter_q;
    assign bus.game_move  = game_move_q;
    assign bus.data       = data_q;
    assign bus.data_sel   = data_sel_q;
    assign bus.data_valid = data_valid_q;
    assign bus.gameover   = gameover_q;
    assign bus.lostwon    = lostwon_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_corral_ctrl.sv
// Directed self-checking bench for corral_ctrl; the timeout scenario runs
// only when CORRAL_TIMEOUT_EN is defined.
module tb_corral_ctrl;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   enter_cnt = 0;

    corral_if bus ();

    corral_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts engine strobes; each strobe lasts one full cycle.
    always @(negedge clock) begin
        if (bus.game_enter === 1'b1) enter_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] mv, input string tag);
        bus.move_valid = 1'b1;
        bus.move       = mv;
        check({tag, "_ready"}, 8'(bus.move_ready), 8'd1);
        tick();
        bus.move_valid = 1'b0;
    endtask

    task automatic wait_enter(input logic [2:0] mv, input string tag);
        int n = 0;
        while (bus.game_enter !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_enter"}, 8'(bus.game_enter), 8'd1);
        check({tag, "_move"}, 8'(bus.game_move), 8'(mv));
    endtask

    task automatic reply(input logic [3:0] cow, input logic [3:0] hor,
                         input logic go, input logic lw, input string tag);
        bus.game_ready     = 1'b1;
        bus.game_cowboypos = cow;
        bus.game_horsepos  = hor;
        bus.game_gameover  = go;
        bus.game_lostwon   = lw;
        tick();
        bus.game_ready = 1'b0;
        check({tag, "_c_data"}, 8'(bus.data), 8'(cow));
        check({tag, "_c_sel"}, 8'(bus.data_sel), 8'd0);
        check({tag, "_c_vld"}, 8'(bus.data_valid), 8'd1);
        check({tag, "_gameover"}, 8'(bus.gameover), 8'(go));
        tick();
        check({tag, "_h_data"}, 8'(bus.data), 8'(hor));
        check({tag, "_h_sel"}, 8'(bus.data_sel), 8'd1);
        check({tag, "_h_vld"}, 8'(bus.data_valid), 8'd1);
        tick();
        check({tag, "_s_data"}, 8'(bus.data), {6'b000000, go, lw});
        check({tag, "_s_sel"}, 8'(bus.data_sel), 8'd2);
        check({tag, "_s_vld"}, 8'(bus.data_valid), 8'd1);
        tick();
        check({tag, "_end_vld"}, 8'(bus.data_valid), 8'd0);
        check({tag, "_end_data"}, 8'(bus.data), 8'd0);
    endtask

    initial begin
        int e0;
        reset_n            = 1'b0;
        bus.move_valid     = 1'b0;
        bus.move           = 3'b000;
        bus.new_game       = 1'b0;
        bus.game_ready     = 1'b0;
        bus.game_cowboypos = 4'h0;
        bus.game_horsepos  = 4'h0;
        bus.game_gameover  = 1'b0;
        bus.game_lostwon   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_enter", 8'(bus.game_enter), 8'd0);
        check("rst_data_valid", 8'(bus.data_valid), 8'd0);
        check("rst_busy", 8'(bus.busy), 8'd0);
        check("rst_gameover", 8'(bus.gameover), 8'd0);
        check("rst_timeout", 8'(bus.timeout_err), 8'd0);
        check("rst_ready", 8'(bus.move_ready), 8'd0);
        reset_n = 1'b1;
        #1;
        check("rel_ready", 8'(bus.move_ready), 8'd1);
        tick();

        // Single move with exact issue latency
        push(3'b101, "t1");
        check("t1_a_enter", 8'(bus.game_enter), 8'd0);
        tick();
        check("t1_b_enter", 8'(bus.game_enter), 8'd0);
        check("t1_b_busy", 8'(bus.busy), 8'd1);
        tick();
        check("t1_c_enter", 8'(bus.game_enter), 8'd1);
        check("t1_c_move", 8'(bus.game_move), 8'b101);
        tick();
        check("t1_strobe_len", 8'(bus.game_enter), 8'd0);
        tick();
        tick();
        reply(4'h2, 4'h9, 1'b0, 1'b0, "t1");
        check("t1_idle", 8'(bus.busy), 8'd0);
        check("t1_enters", 8'(enter_cnt), 8'd1);

        // Backpressure while the engine stalls
        push(3'b001, "t2a");
        wait_enter(3'b001, "t2a");
        push(3'b010, "t2b");
        push(3'b011, "t2c");
        bus.move_valid = 1'b1;
        bus.move       = 3'b100;
        check("t2_full_ready", 8'(bus.move_ready), 8'd0);
        tick();
        bus.move_valid = 1'b0;
        check("t2_still_busy", 8'(bus.busy), 8'd1);
        reply(4'h1, 4'h2, 1'b0, 1'b0, "t2a");
        wait_enter(3'b010, "t2b");
        reply(4'h3, 4'h4, 1'b0, 1'b0, "t2b");
        wait_enter(3'b011, "t2c");
        reply(4'h5, 4'h6, 1'b0, 1'b0, "t2c");
        e0 = enter_cnt;
        repeat (6) tick();
        check("t2_third_dropped", 8'(enter_cnt - e0), 8'd0);
        check("t2_idle", 8'(bus.busy), 8'd0);

        // Game over and restart
        push(3'b110, "t3");
        wait_enter(3'b110, "t3");
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        check("t3_newgame_ignored", 8'(bus.busy), 8'd1);
        reply(4'h5, 4'h7, 1'b1, 1'b1, "t3");
        check("t3_over_gameover", 8'(bus.gameover), 8'd1);
        check("t3_over_lostwon", 8'(bus.lostwon), 8'd1);
        check("t3_over_busy", 8'(bus.busy), 8'd1);
        bus.move_valid = 1'b1;
        bus.move       = 3'b111;
        check("t3_over_ready", 8'(bus.move_ready), 8'd0);
        tick();
        tick();
        check("t3_over_ready2", 8'(bus.move_ready), 8'd0);
        bus.move_valid = 1'b0;
        bus.new_game   = 1'b1;
        tick();
        bus.new_game = 1'b0;
        check("t3_clr_gameover", 8'(bus.gameover), 8'd0);
        check("t3_clr_lostwon", 8'(bus.lostwon), 8'd0);
        check("t3_clr_busy", 8'(bus.busy), 8'd0);
        check("t3_clr_ready", 8'(bus.move_ready), 8'd1);
        repeat (4) tick();
        check("t3_no_stale_move", 8'(bus.busy), 8'd0);

`ifdef CORRAL_TIMEOUT_EN
        // Engine never answers: timeout after 8 WAIT cycles
        push(3'b011, "t4");
        wait_enter(3'b011, "t4");
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t4_pre_timeout", 8'(bus.timeout_err), 8'd0);
            check("t4_pre_valid", 8'(bus.data_valid), 8'd0);
        end
        tick();
        check("t4_timeout", 8'(bus.timeout_err), 8'd1);
        check("t4_gameover", 8'(bus.gameover), 8'd1);
        check("t4_lostwon", 8'(bus.lostwon), 8'd0);
        check("t4_valid", 8'(bus.data_valid), 8'd0);
        check("t4_ready", 8'(bus.move_ready), 8'd0);
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        check("t4_clr_timeout", 8'(bus.timeout_err), 8'd0);
        check("t4_clr_busy", 8'(bus.busy), 8'd0);
`endif

        // Reset in WAIT with one move queued
        push(3'b001, "t5a");
        wait_enter(3'b001, "t5a");
        push(3'b010, "t5b");
        reset_n = 1'b0;
        #1;
        check("t5_rst_enter", 8'(bus.game_enter), 8'd0);
        check("t5_rst_busy", 8'(bus.busy), 8'd0);
        check("t5_rst_valid", 8'(bus.data_valid), 8'd0);
        check("t5_rst_timeout", 8'(bus.timeout_err), 8'd0);
        tick();
        reset_n = 1'b1;
        e0 = enter_cnt;
        repeat (10) tick();
        check("t5_no_enter", 8'(enter_cnt - e0), 8'd0);
        check("t5_fifo_empty", 8'(bus.busy), 8'd0);
        check("t5_ready", 8'(bus.move_ready), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
